// File: rtl/regfile_pkg.sv
// Shared constants and types for the RV32I register file with hazard scoreboard.
// No ports; imported by the interface, the scoreboard and the top.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned ZERO_REG  = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_bypass_if.sv
// Decode/writeback bus of the register file.
// master (pipeline side): drives read addresses, writeback and issue; receives read data,
//   busy flags, busy_count and sb_overflow.
// slave (register file side): the mirror image.
interface regfile_bypass_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
) ();

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(NREGS) + 1;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                RegWrite;
  logic [AW-1:0]       write_register;
  logic [XLEN-1:0]     write_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [CW-1:0]       busy_count;
  logic                sb_overflow;

  modport master (
    output rd_addr, RegWrite, write_register, write_data, issue_valid, issue_rd,
    input  rd_data, rd_busy, busy_count, sb_overflow
  );

  modport slave (
    input  rd_addr, RegWrite, write_register, write_data, issue_valid, issue_rd,
    output rd_data, rd_busy, busy_count, sb_overflow
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, an incrementally maintained
// popcount and a sticky overflow flag for issue to an already-busy register.
// Ports: clk, rst (async, active-high); set_en/set_addr (issue); clr_en/clr_addr
// (writeback); busy (per-register query vector), busy_count, overflow.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS),
  localparam int unsigned CW    = $clog2(NREGS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_count,
  output logic             overflow
);

  logic             set_v;
  logic             clr_v;
  logic             same;
  logic             inc;
  logic             dec;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    count_nxt;
  logic             overflow_nxt;

  // Next scoreboard state; a set and clear of the same register leaves it busy.
  always_comb begin
    set_v        = set_en && (set_addr != AW'(ZERO_REG));
    clr_v        = clr_en && (clr_addr != AW'(ZERO_REG));
    same         = set_v && clr_v && (set_addr == clr_addr);
    busy_nxt     = busy;
    if (clr_v) busy_nxt[clr_addr] = 1'b0;
    if (set_v) busy_nxt[set_addr] = 1'b1;
    inc          = set_v && !busy[set_addr];
    dec          = clr_v && busy[clr_addr] && !same;
    count_nxt    = busy_count + CW'(inc) - CW'(dec);
    overflow_nxt = overflow || (set_v && busy[set_addr] && !same);
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      overflow   <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Multi-read-port integer register file with async reset, r0 hardwired to zero and a
// pending-write scoreboard for RAW hazard detection.
// Ports: clk, rst (async, active-high); bus (regfile_bypass_if.slave) carrying read
// addresses/data/busy, writeback, issue, busy_count and sb_overflow.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input logic             clk,
  input logic             rst,
  regfile_bypass_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_v;

  assign wr_v = bus.RegWrite && (bus.write_register != AW'(ZERO_REG));

  // Data array; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_v) begin
      regs[bus.write_register] <= bus.write_data;
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (bus.issue_valid),
    .set_addr   (bus.issue_rd),
    .clr_en     (bus.RegWrite),
    .clr_addr   (bus.write_register),
    .busy       (busy),
    .busy_count (bus.busy_count),
    .overflow   (bus.sb_overflow)
  );

  // Combinational read ports; forced to zero while in reset.
  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy_q;

    assign addr = bus.rd_addr[g*AW +: AW];

    always_comb begin
      data   = '0;
      busy_q = 1'b0;
      if (!rst && (addr != AW'(ZERO_REG))) begin
        data   = regs[addr];
        busy_q = busy[addr];
`ifdef REGFILE_BYPASS_EN
        // The writeback retires the producer, unless a new one issues to it now.
        if (wr_v && (bus.write_register == addr)) begin
          data = bus.write_data;
          if (!(bus.issue_valid && (bus.issue_rd == addr))) busy_q = 1'b0;
        end
`endif
      end
    end

    assign bus.rd_data[g*XLEN +: XLEN] = data;
    assign bus.rd_busy[g]              = busy_q;
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass (NRD=3) against an array-based reference model.
module tb_regfile_bypass;
  import regfile_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 3;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_bypass_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_ovf;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_ovf  = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.write_register != 0 && bus.write_register == a) return bus.write_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.write_register != 0 && bus.write_register == a &&
        !(bus.issue_valid && bus.issue_rd == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Apply the rising-edge rules to the model, using the inputs currently driven.
  task automatic model_edge();
    logic we, iv;
    we = bus.RegWrite && bus.write_register != 0;
    iv = bus.issue_valid && bus.issue_rd != 0;
    if (iv && m_busy[bus.issue_rd] && !(we && bus.write_register == bus.issue_rd)) m_ovf = 1'b1;
    if (we) begin
      m_regs[bus.write_register] = bus.write_data;
      m_busy[bus.write_register] = 1'b0;
    end
    if (iv) m_busy[bus.issue_rd] = 1'b1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.RegWrite       = we;
    bus.write_register = wr;
    bus.write_data     = wd;
    bus.issue_valid    = iv;
    bus.issue_rd       = ird;
    bus.rd_addr        = {a2, a1, a0};
  endtask

  task automatic check_outputs();
    logic [4:0] a;
    for (int i = 0; i < int'(NRD); i++) begin
      a = bus.rd_addr[i*AW +: AW];
      check($sformatf("rd_data%0d[a=%0d]", i, a), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(exp_rd(a)));
      check($sformatf("rd_busy%0d[a=%0d]", i, a), 64'(bus.rd_busy[i]), 64'(exp_busy(a)));
    end
    check("busy_count", 64'(bus.busy_count), 64'($countones(m_busy)));
    check("sb_overflow", 64'(bus.sb_overflow), 64'(m_ovf));
  endtask

  // One cycle: drive at negedge, check before the edge, update model at the edge.
  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    drive(we, wr, wd, iv, ird, a0, a1, a2);
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [4:0]  rw, ra0, ra1, ra2;
  logic [31:0] rd;

  initial begin
    rst = 1'b0;
    @(negedge clk);
    do_reset();
    #1 check_outputs();
    @(negedge clk);

    // Reset asserted mid-cycle clears data and scoreboard immediately
    cycle(1, 5, 32'h1234, 1, 5, 5, 5, 5);
    drive(0, 0, 0, 0, 0, 5, 5, 5);
    #1 check_outputs();
    #2 rst = 1'b1;
    #1;
    check("rst_rd_data", 64'(bus.rd_data[XLEN-1:0]), 64'h0);
    check("rst_rd_busy", 64'(bus.rd_busy), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 check_outputs();
    check("rst_busy_count", 64'(bus.busy_count), 64'h0);
    @(negedge clk);

    // Writes and issues to r0 are dropped
    cycle(1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_busy_count", 64'(bus.busy_count), 64'h0);

    // Issue then writeback of r7
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 5'd0);
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd7);

    // Simultaneous issue and writeback of busy r3: set wins
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd3, 5'd3, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3);
    check("set_wins_count", 64'(bus.busy_count), 64'h1);
    cycle(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd0, 5'd0);

    // Double issue of r9 -> sticky overflow
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, 5'd0);
    check("ovf_sticky", 64'(bus.sb_overflow), 64'h1);

    // All ports read the same register
    cycle(1'b1, 5'd12, 32'h0F0F0000, 1'b0, 5'd0, 5'd12, 5'd12, 5'd12);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12, 5'd12);

    // Fill the scoreboard: count reaches 31, no wrap on further issues
    do_reset();
    @(negedge clk);
    for (int r = 1; r < 32; r++) cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'(r), 5'(32 - r), 5'd0);
    check("fill_count", 64'(bus.busy_count), 64'd31);
    check("fill_no_ovf", 64'(bus.sb_overflow), 64'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd1, 5'd2);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    check("full_no_wrap", 64'(bus.busy_count), 64'd31);

    // Randomized traffic, starting from a clean state
    do_reset();
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      rw  = 5'($urandom_range(0, 31));
      rd  = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), rw, rd, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31)), ra0, ra1, ra2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
